// File: rtl/shared_mem_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : shared_mem_adapter
//  Description : Two-master (instruction A / data B) adapter onto a single
//                single-ported, byte-writable RAM with per-port read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module shared_mem_adapter #(
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 32,
   parameter int RD_LAT_A = 1,
   parameter int RD_LAT_B = 2,
   parameter int ARB_RR   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rea,
   input  logic [DATA_W/8-1:0]   wea,
   input  logic [ADDR_W-1:0]     addra,
   input  logic [DATA_W-1:0]     dina,
   output logic [DATA_W-1:0]     douta,
   output logic                  dreadya,
   input  logic                  reb,
   input  logic [DATA_W/8-1:0]   web,
   input  logic [ADDR_W-1:0]     addrb,
   input  logic [DATA_W-1:0]     dinb,
   output logic [DATA_W-1:0]     doutb,
   output logic                  dreadyb
);

   localparam int         c_be_w       = DATA_W / 8;
   localparam int         c_depth      = 2 ** ADDR_W;
   localparam logic [2:0] c_lat_a      = 3'(RD_LAT_A);
   localparam logic [2:0] c_lat_b      = 3'(RD_LAT_B);
   localparam logic       c_fixed_prio = (ARB_RR == 0);

   localparam logic [0:0] c_st_idle    = 1'b0;
   localparam logic [0:0] c_st_rd_wait = 1'b1;

   logic [DATA_W-1:0] r_mem [c_depth];

   logic [0:0]        r_state;
   logic [2:0]        r_cnt;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_rd_own_b;
   logic              r_rr_prio_b;
   logic [DATA_W-1:0] r_douta;
   logic [DATA_W-1:0] r_doutb;
   logic              r_dreadya;
   logic              r_dreadyb;

   logic              w_req_a;
   logic              w_req_b;
   logic              w_sel_b;
   logic              w_grant;
   logic [c_be_w-1:0] w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_din;
   logic              w_is_wr;
   logic [2:0]        w_lat;
   logic              w_mem_we;

   // A port is masked in its own completion cycle so a held request restarts cleanly
   assign w_req_a  = (rea | (|wea)) & ~r_dreadya;
   assign w_req_b  = (reb | (|web)) & ~r_dreadyb;
   assign w_sel_b  = w_req_b & (~w_req_a | c_fixed_prio | r_rr_prio_b);
   assign w_grant  = (r_state == c_st_idle) & (w_req_a | w_req_b);

   assign w_we     = w_sel_b ? web   : wea;
   assign w_addr   = w_sel_b ? addrb : addra;
   assign w_din    = w_sel_b ? dinb  : dina;
   assign w_lat    = w_sel_b ? c_lat_b : c_lat_a;
   assign w_is_wr  = |w_we;
   assign w_mem_we = w_grant & w_is_wr & rst_n;

   always_ff @(posedge clk) begin : p_mem
      if (w_mem_we) begin
         for (int b = 0; b < c_be_w; b++) begin
            if (w_we[b]) begin
               r_mem[w_addr][b*8 +: 8] <= w_din[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : p_ctrl
      if (!rst_n) begin
         r_state     <= c_st_idle;
         r_cnt       <= 3'd0;
         r_rd_addr   <= '0;
         r_rd_own_b  <= 1'b0;
         r_rr_prio_b <= 1'b0;
         r_douta     <= '0;
         r_doutb     <= '0;
         r_dreadya   <= 1'b0;
         r_dreadyb   <= 1'b0;
      end else begin
         r_dreadya <= 1'b0;
         r_dreadyb <= 1'b0;
         case (r_state)
            c_st_idle: begin
               if (w_grant) begin
                  r_rr_prio_b <= ~w_sel_b;
                  if (w_is_wr || (w_lat == 3'd1)) begin
                     if (w_sel_b) begin
                        r_dreadyb <= 1'b1;
                        if (!w_is_wr) r_doutb <= r_mem[w_addr];
                     end else begin
                        r_dreadya <= 1'b1;
                        if (!w_is_wr) r_douta <= r_mem[w_addr];
                     end
                  end else begin
                     r_state    <= c_st_rd_wait;
                     r_cnt      <= w_lat - 3'd1;
                     r_rd_addr  <= w_addr;
                     r_rd_own_b <= w_sel_b;
                  end
               end
            end
            c_st_rd_wait: begin
               // No grants here, so the RAM cannot change under the pending read
               if (r_cnt == 3'd1) begin
                  r_state <= c_st_idle;
                  r_cnt   <= 3'd0;
                  if (r_rd_own_b) begin
                     r_dreadyb <= 1'b1;
                     r_doutb   <= r_mem[r_rd_addr];
                  end else begin
                     r_dreadya <= 1'b1;
                     r_douta   <= r_mem[r_rd_addr];
                  end
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign douta   = r_douta;
   assign doutb   = r_doutb;
   assign dreadya = r_dreadya;
   assign dreadyb = r_dreadyb;

endmodule
`default_nettype wire

// File: tb/tb_shared_mem_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shared_mem_adapter
//  Description : Scoreboard bench for shared_mem_adapter, fixed-priority and
//                round-robin instances driven by random and directed traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_mem_adapter;

   typedef struct {
      logic [3:0]  we;
      logic [6:0]  addr;
      logic [31:0] din;
      int          gap;
   } op_t;

   typedef struct {
      int          due;
      logic [31:0] data;
      bit          rd;
   } exp_t;

   logic clk;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   done [2];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input int inst, input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL inst%0d %s: got %h expected %h", inst, nm, got, exp);
      end
   endtask

   task automatic flag(input int inst, input string nm, input int got, input int exp);
      n_chk++;
      n_fail++;
      $display("FAIL inst%0d %s: got %0d expected %0d", inst, nm, got, exp);
   endtask

   function automatic op_t mk_op(input logic [3:0] we, input logic [6:0] addr, input logic [31:0] din, input int gap);
      op_t o;
      o.we = we; o.addr = addr; o.din = din; o.gap = gap;
      return o;
   endfunction

   function automatic op_t rand_op();
      logic [3:0] we;
      int         gap;
      we  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      return mk_op(we, 7'($urandom_range(0, 15)), $urandom, gap);
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      // Instance 0: fixed priority, default latencies; instance 1: round-robin, slower reads
      localparam int LA = (gi == 0) ? 1 : 2;
      localparam int LB = (gi == 0) ? 2 : 3;
      localparam int RR = (gi == 0) ? 0 : 1;

      logic        rst_n;
      logic        rea, reb;
      logic [3:0]  wea, web;
      logic [6:0]  addra, addrb;
      logic [31:0] dina, dinb, douta, doutb;
      logic        dreadya, dreadyb;

      op_t  opq_a [$];
      op_t  opq_b [$];
      exp_t qa [$];
      exp_t qb [$];
      bit   busy_a, busy_b;

      shared_mem_adapter #(
         .ADDR_W(7), .DATA_W(32), .RD_LAT_A(LA), .RD_LAT_B(LB), .ARB_RR(RR)
      ) u_dut (
         .clk(clk), .rst_n(rst_n),
         .rea(rea), .wea(wea), .addra(addra), .dina(dina), .douta(douta), .dreadya(dreadya),
         .reb(reb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb), .dreadyb(dreadyb)
      );

      initial begin : drv_a
         op_t op; int hold; int gap;
         rea = 1'b0; wea = 4'h0; addra = '0; dina = '0; busy_a = 1'b0; hold = 0; gap = 0;
         forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
               busy_a = 1'b0; rea = 1'b0; wea = 4'h0; gap = 0; opq_a.delete();
            end else begin
               if (busy_a) begin
                  hold++;
                  if (dreadya) begin
                     busy_a = 1'b0; rea = 1'b0; wea = 4'h0;
                  end else if (hold > 40) begin
                     flag(gi, "a_op_timeout", hold, 40);
                     busy_a = 1'b0; rea = 1'b0; wea = 4'h0;
                  end
               end
               if (!busy_a) begin
                  if (gap > 0) gap--;
                  else if (opq_a.size() > 0) begin
                     op = opq_a.pop_front();
                     rea = (op.we == 4'h0) | 1'($urandom_range(0, 1));
                     wea = op.we; addra = op.addr; dina = op.din; gap = op.gap;
                     busy_a = 1'b1; hold = 0;
                  end
               end
            end
         end
      end

      initial begin : drv_b
         op_t op; int hold; int gap;
         reb = 1'b0; web = 4'h0; addrb = '0; dinb = '0; busy_b = 1'b0; hold = 0; gap = 0;
         forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
               busy_b = 1'b0; reb = 1'b0; web = 4'h0; gap = 0; opq_b.delete();
            end else begin
               if (busy_b) begin
                  hold++;
                  if (dreadyb) begin
                     busy_b = 1'b0; reb = 1'b0; web = 4'h0;
                  end else if (hold > 40) begin
                     flag(gi, "b_op_timeout", hold, 40);
                     busy_b = 1'b0; reb = 1'b0; web = 4'h0;
                  end
               end
               if (!busy_b) begin
                  if (gap > 0) gap--;
                  else if (opq_b.size() > 0) begin
                     op = opq_b.pop_front();
                     reb = (op.we == 4'h0) | 1'($urandom_range(0, 1));
                     web = op.we; addrb = op.addr; dinb = op.din; gap = op.gap;
                     busy_b = 1'b1; hold = 0;
                  end
               end
            end
         end
      end

      // Transaction-level reference: a grant is allowed once the previous
      // operation's completion cycle is reached; the expected completion is pushed.
      initial begin : model
         logic [31:0] mm [128];
         int free_at, done_a, done_b, lat;
         bit prio_b, ma, mb, pick_b;
         logic [31:0] la, lb;
         logic [3:0]  we;
         logic [6:0]  ad;
         logic [31:0] dn;
         exp_t e;
         free_at = 0; done_a = -1; done_b = -1; prio_b = 1'b0; la = '0; lb = '0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               free_at = 0; done_a = -1; done_b = -1; prio_b = 1'b0; la = '0; lb = '0;
               qa.delete(); qb.delete();
            end else begin
               ma = (rea || wea != 4'h0) && (done_a != cyc);
               mb = (reb || web != 4'h0) && (done_b != cyc);
               if (cyc >= free_at && (ma || mb)) begin
                  pick_b = mb && (!ma || RR == 0 || prio_b);
                  prio_b = !pick_b;
                  we = pick_b ? web : wea;
                  ad = pick_b ? addrb : addra;
                  dn = pick_b ? dinb : dina;
                  if (we != 4'h0) begin
                     for (int b = 0; b < 4; b++) if (we[b]) mm[ad][b*8 +: 8] = dn[b*8 +: 8];
                     lat = 1;
                     e.rd = 1'b0;
                     e.data = pick_b ? lb : la;
                  end else begin
                     lat = pick_b ? LB : LA;
                     e.rd = 1'b1;
                     e.data = mm[ad];
                     if (pick_b) lb = mm[ad]; else la = mm[ad];
                  end
                  e.due = cyc + lat;
                  free_at = cyc + lat;
                  if (pick_b) begin done_b = cyc + lat; qb.push_back(e); end
                  else begin done_a = cyc + lat; qa.push_back(e); end
               end
            end
         end
      end

      initial begin : monitor
         forever begin
            @(negedge clk);
            if (rst_n) begin
               if (dreadya && dreadyb) flag(gi, "both_dready", 1, 0);
               if (dreadya) begin
                  if (qa.size() == 0 || qa[0].due != cyc)
                     flag(gi, "a_dready_timing", cyc, (qa.size() == 0) ? -1 : qa[0].due);
                  else begin
                     chk(gi, qa[0].rd ? "a_read_data" : "a_dout_hold", douta, qa[0].data);
                     void'(qa.pop_front());
                  end
               end else if (qa.size() > 0 && qa[0].due <= cyc) begin
                  flag(gi, "a_missing_dready", cyc, qa[0].due);
                  void'(qa.pop_front());
               end
               if (dreadyb) begin
                  if (qb.size() == 0 || qb[0].due != cyc)
                     flag(gi, "b_dready_timing", cyc, (qb.size() == 0) ? -1 : qb[0].due);
                  else begin
                     chk(gi, qb[0].rd ? "b_read_data" : "b_dout_hold", doutb, qb[0].data);
                     void'(qb.pop_front());
                  end
               end else if (qb.size() > 0 && qb[0].due <= cyc) begin
                  flag(gi, "b_missing_dready", cyc, qb[0].due);
                  void'(qb.pop_front());
               end
            end
         end
      end

      task automatic wait_idle();
         int k;
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (k < 3000 && !(opq_a.size() == 0 && opq_b.size() == 0 &&
                    qa.size() == 0 && qb.size() == 0 && !busy_a && !busy_b));
         if (k >= 3000) flag(gi, "drain_timeout", k, 3000);
         repeat (2) @(negedge clk);
      endtask

      task automatic chk_outs_zero(input string nm);
         chk(gi, {nm, "_douta"}, douta, 32'h0);
         chk(gi, {nm, "_doutb"}, doutb, 32'h0);
         chk(gi, {nm, "_dreadya"}, 32'(dreadya), 32'h0);
         chk(gi, {nm, "_dreadyb"}, 32'(dreadyb), 32'h0);
      endtask

      initial begin : main
         done[gi] = 1'b0;
         rst_n = 1'b0;
         #3;
         chk_outs_zero("reset");
         repeat (3) @(negedge clk);
         #2 rst_n = 1'b1;
         repeat (3) @(negedge clk);
         chk_outs_zero("idle_after_reset");

         for (int a = 0; a < 16; a++) opq_a.push_back(mk_op(4'hF, 7'(a), $urandom, 0));
         wait_idle();

         opq_a.push_back(mk_op(4'hF, 7'd5, 32'hDEADBEEF, 0));
         opq_a.push_back(mk_op(4'h0, 7'd5, 32'h0, 0));
         wait_idle();
         chk(gi, "write_then_read_a", douta, 32'hDEADBEEF);

         opq_a.push_back(mk_op(4'hF, 7'd9, 32'h11223344, 0));
         opq_a.push_back(mk_op(4'b0010, 7'd9, 32'hAABBCCDD, 0));
         opq_a.push_back(mk_op(4'h0, 7'd9, 32'h0, 0));
         wait_idle();
         chk(gi, "byte_enable_merge", douta, 32'h1122CC44);

         // Simultaneous writes, then continuous conflicting traffic, then cross-port reads
         for (int k = 0; k < 8; k++) begin
            opq_a.push_back(mk_op(4'hF, 7'(k), $urandom, 0));
            opq_b.push_back(mk_op(4'hF, 7'(k + 8), $urandom, 0));
         end
         for (int k = 0; k < 8; k++) begin
            opq_a.push_back(mk_op(4'h0, 7'(k + 8), 32'h0, 0));
            opq_b.push_back(mk_op(4'h0, 7'(k), 32'h0, 0));
         end
         wait_idle();

         for (int k = 0; k < 120; k++) begin
            opq_a.push_back(rand_op());
            opq_b.push_back(rand_op());
         end
         repeat (150) @(posedge clk);
         #3 rst_n = 1'b0;
         #1 chk_outs_zero("async_reset");
         @(negedge clk);
         @(negedge clk);
         #2 rst_n = 1'b1;
         repeat (2) @(negedge clk);
         chk_outs_zero("idle_after_midrun_reset");
         wait_idle();

         for (int a = 0; a < 16; a++) begin
            opq_a.push_back(mk_op(4'h0, 7'(a), 32'h0, 0));
            opq_b.push_back(mk_op(4'h0, 7'(15 - a), 32'h0, 0));
         end
         for (int k = 0; k < 80; k++) begin
            opq_a.push_back(rand_op());
            opq_b.push_back(rand_op());
         end
         wait_idle();
         done[gi] = 1'b1;
      end
   end

   initial begin : top_ctl
      int k;
      k = 0;
      while (!(done[0] && done[1]) && k < 60000) begin
         @(posedge clk);
         k++;
      end
      if (!(done[0] && done[1])) flag(-1, "global_timeout", k, 60000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
